// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the timed LCD 8080 PHY.
// FSM encoding, RS values, default strobe timing, fmark filter length.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } lcd_state_t;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // cfg 0/0 gives the 2-cycle legacy period
  localparam int DEF_WR_LOW  = 0;
  localparam int DEF_WR_HIGH = 0;

  // fmark must hold this many samples to move the filtered level
  localparam int FILT_LEN = 4;

endpackage

// File: rtl/lcd_fmark_sync.sv
// lcd_fmark_sync: fmark synchroniser, optional glitch filter
// (LCD_PHY_FMARK_FILTER_EN), rising-edge strobe and frame counter.
// Ports: clk, rst, i_fmark (async), o_stb (1-cycle), o_frame_cnt.
module lcd_fmark_sync
  import lcd_pkg::*;
#(
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_fmark,
  output logic           o_stb,
  output logic [FCW-1:0] o_frame_cnt
);

  logic           r_s1;
  logic           r_s2;
  logic           r_s3;
  logic           r_stb;
  logic [FCW-1:0] r_cnt;
  logic           w_lvl;
  logic           w_rise;

`ifdef LCD_PHY_FMARK_FILTER_EN
  logic       r_filt;
  logic [1:0] r_run;

  // r_run counts consecutive samples that disagree with r_filt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= 1'b0;
      r_run  <= '0;
    end else if (r_s2 == r_filt) begin
      r_run  <= '0;
    end else if (r_run == 2'(FILT_LEN - 1)) begin
      r_filt <= r_s2;
      r_run  <= '0;
    end else begin
      r_run  <= r_run + 2'd1;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_s2;
`endif

  assign w_rise = w_lvl & ~r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_stb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1  <= i_fmark;
      r_s2  <= r_s1;
      r_s3  <= w_lvl;
      r_stb <= w_rise;
      if (w_rise) begin
        r_cnt <= r_cnt + FCW'(1);
      end
    end
  end

  assign o_stb       = r_stb;
  assign o_frame_cnt = r_cnt;

endmodule

// File: rtl/lcd_phy_timed.sv
// lcd_phy_timed: 8080-style LCD write PHY with run-time wr_n timing.
// Ports: cfg_wr_low/high, phy_* request side, lcd_* registered pads,
// lcd_fmark in, fmark strobe + frame count out.
// Optional macro LCD_PHY_FMARK_FILTER_EN adds the fmark glitch filter.
module lcd_phy_timed
  import lcd_pkg::*;
#(
  parameter int DW  = 8,
  parameter int TW  = 4,
  parameter int FCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TW-1:0]  cfg_wr_low,
  input  logic [TW-1:0]  cfg_wr_high,
  input  logic           phy_ena,
  input  logic [DW-1:0]  phy_data,
  input  logic           phy_rs,
  input  logic           phy_valid,
  output logic           phy_ready,
  output logic           phy_busy,
  output logic           phy_fmark_stb,
  output logic [FCW-1:0] phy_frame_cnt,
  output logic [DW-1:0]  lcd_d,
  output logic           lcd_rs,
  output logic           lcd_wr_n,
  output logic           lcd_oe,
  input  logic           lcd_fmark
);

  lcd_state_t    r_state;
  logic [TW-1:0] r_cnt;
  logic [DW-1:0] r_d;
  logic          r_rs;
  logic          r_wr_n;
  logic          r_oe;
  logic          w_zero;
  logic          w_ready;
  logic          w_acc;

  assign w_zero  = (r_cnt == '0);
  // last HIGH cycle may accept so words go out back-to-back
  assign w_ready = (r_state == IDLE) |
                   ((r_state == HIGH) & w_zero);
  assign w_acc   = phy_valid & w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_rs    <= RS_CMD;
      r_wr_n  <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_oe <= phy_ena;
      if (w_acc) begin
        r_state <= LOW;
        r_d     <= phy_data;
        r_rs    <= phy_rs;
        r_wr_n  <= 1'b0;
        r_cnt   <= cfg_wr_low;
      end else begin
        unique case (r_state)
          IDLE: begin
          end
          LOW: begin
            if (w_zero) begin
              r_wr_n  <= 1'b1;
              r_cnt   <= cfg_wr_high;
              r_state <= HIGH;
            end else begin
              r_cnt <= r_cnt - TW'(1);
            end
          end
          HIGH: begin
            if (w_zero) begin
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt - TW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign phy_ready = w_ready;
  assign phy_busy  = (r_state != IDLE);
  assign lcd_d     = r_d;
  assign lcd_rs    = r_rs;
  assign lcd_wr_n  = r_wr_n;
  assign lcd_oe    = r_oe;

  lcd_fmark_sync #(
    .FCW(FCW)
  ) u_fmark (
    .clk        (clk),
    .rst        (rst),
    .i_fmark    (lcd_fmark),
    .o_stb      (phy_fmark_stb),
    .o_frame_cnt(phy_frame_cnt)
  );

endmodule

// File: tb/tb_lcd_phy_timed.sv
// tb_lcd_phy_timed: directed bench with a cycle-indexed reference model.
// Honours LCD_PHY_FMARK_FILTER_EN for the fmark expectations.
module tb_lcd_phy_timed;
  import lcd_pkg::*;

  localparam int DW  = 8;
  localparam int TW  = 4;
  localparam int FCW = 8;
  localparam int BIG = 1 << 30;
`ifdef LCD_PHY_FMARK_FILTER_EN
  localparam int LAT        = 3 + FILT_LEN;
  localparam int GLITCH_STB = 0;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_STB = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [TW-1:0]  cfg_wr_low;
  logic [TW-1:0]  cfg_wr_high;
  logic           phy_ena;
  logic [DW-1:0]  phy_data;
  logic           phy_rs;
  logic           phy_valid;
  logic           phy_ready;
  logic           phy_busy;
  logic           phy_fmark_stb;
  logic [FCW-1:0] phy_frame_cnt;
  logic [DW-1:0]  lcd_d;
  logic           lcd_rs;
  logic           lcd_wr_n;
  logic           lcd_oe;
  logic           lcd_fmark;

  lcd_phy_timed #(.DW(DW), .TW(TW), .FCW(FCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_low   (cfg_wr_low),
    .cfg_wr_high  (cfg_wr_high),
    .phy_ena      (phy_ena),
    .phy_data     (phy_data),
    .phy_rs       (phy_rs),
    .phy_valid    (phy_valid),
    .phy_ready    (phy_ready),
    .phy_busy     (phy_busy),
    .phy_fmark_stb(phy_fmark_stb),
    .phy_frame_cnt(phy_frame_cnt),
    .lcd_d        (lcd_d),
    .lcd_rs       (lcd_rs),
    .lcd_wr_n     (lcd_wr_n),
    .lcd_oe       (lcd_oe),
    .lcd_fmark    (lcd_fmark)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model. Each write is described by the cycle it was
  // accepted in (m_start), its last wr_n-low cycle (m_low_to) and its
  // last busy cycle (m_end), cycle n meaning "after the n-th edge".
  bit             m_init = 0;
  int             m_start, m_low_to, m_end;
  bit             m_hpend;
  logic [DW-1:0]  m_d;
  logic           m_rs, m_oe, m_stb;
  logic [FCW-1:0] m_cnt;
  logic           h [8];
  logic           lv[8];

  function automatic bit e_low(int n);
    return n >= m_start && n <= m_low_to;
  endfunction
  function automatic bit e_busy(int n);
    return n >= m_start && n <= m_end;
  endfunction
  function automatic bit e_rdy(int n);
    return !e_busy(n) || n == m_end;
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    int c;
    cyc++;
    c   = cyc;
    acc = !rst && phy_valid && e_rdy(c - 1);
    if (rst) begin
      m_init   = 1;
      m_start  = -10;
      m_low_to = -10;
      m_end    = -10;
      m_hpend  = 0;
      m_d      = '0;
      m_rs     = 1'b0;
      m_oe     = 1'b0;
      m_stb    = 1'b0;
      m_cnt    = '0;
      for (int k = 0; k < 8; k++) begin
        h[k]  = 1'b0;
        lv[k] = 1'b0;
      end
    end else begin
      m_oe = phy_ena;
      if (m_hpend && c == m_low_to + 1) begin
        m_end   = c + int'(cfg_wr_high);
        m_hpend = 0;
      end
      if (acc) begin
        m_start  = c;
        m_low_to = c + int'(cfg_wr_low);
        m_end    = BIG;
        m_hpend  = 1;
        m_d      = phy_data;
        m_rs     = phy_rs;
      end
      h[c & 7] = lcd_fmark;
`ifdef LCD_PHY_FMARK_FILTER_EN
      // level follows the synchronised input once 4 samples agree
      if (h[(c-5) & 7] == h[(c-4) & 7] &&
          h[(c-4) & 7] == h[(c-3) & 7] &&
          h[(c-3) & 7] == h[(c-2) & 7])
        lv[c & 7] = h[(c-2) & 7];
      else
        lv[c & 7] = lv[(c-1) & 7];
`else
      lv[c & 7] = h[(c-1) & 7];
`endif
      m_stb = lv[(c-1) & 7] & ~lv[(c-2) & 7];
      if (m_stb) m_cnt = m_cnt + 8'd1;
    end
  end

  logic [DW:0] rise_q[$];
  logic        prev_wr = 1'b1;
  int          stb_n   = 0;
  int          stb_cyc = 0;

  always @(negedge clk) begin
    if (m_init) begin
      chk("wr_n",  32'(lcd_wr_n),      32'(!e_low(cyc)));
      chk("busy",  32'(phy_busy),      32'(e_busy(cyc)));
      chk("ready", 32'(phy_ready),     32'(e_rdy(cyc)));
      chk("d",     32'(lcd_d),         32'(m_d));
      chk("rs",    32'(lcd_rs),        32'(m_rs));
      chk("oe",    32'(lcd_oe),        32'(m_oe));
      chk("stb",   32'(phy_fmark_stb), 32'(m_stb));
      chk("fcnt",  32'(phy_frame_cnt), 32'(m_cnt));
      if (lcd_wr_n && !prev_wr) rise_q.push_back({lcd_rs, lcd_d});
      prev_wr = lcd_wr_n;
      if (phy_fmark_stb) begin
        stb_n++;
        stb_cyc = cyc;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic rs,
                      output int acyc);
    int n = 0;
    phy_data  = d;
    phy_rs    = rs;
    phy_valid = 1'b1;
    while (!phy_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(phy_ready), 32'd1);
    acyc = cyc + 1;
    @(negedge clk);
    phy_valid = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    lcd_fmark = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_fmark = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin : stim
    logic [DW-1:0] w[4];
    int a[4];
    int e, s0, lows, highs, nrdy;
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst         = 1'b1;
    cfg_wr_low  = TW'(DEF_WR_LOW);
    cfg_wr_high = TW'(DEF_WR_HIGH);
    phy_ena     = 1'b0;
    phy_data    = '0;
    phy_rs      = RS_CMD;
    phy_valid   = 1'b0;
    lcd_fmark   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_wr_n",  32'(lcd_wr_n),      32'd1);
    chk("rst_d",     32'(lcd_d),         32'd0);
    chk("rst_ready", 32'(phy_ready),     32'd1);
    chk("rst_busy",  32'(phy_busy),      32'd0);
    chk("rst_fcnt",  32'(phy_frame_cnt), 32'd0);

    // back-to-back words at the minimum 2-cycle period
    phy_ena = 1'b1;
    rise_q.delete();
    for (int i = 0; i < 4; i++)
      send(w[i], (i % 2 == 1) ? RS_DATA : RS_CMD, a[i]);
    repeat (6) @(negedge clk);
    for (int i = 1; i < 4; i++)
      chk("b2b_period", 32'(a[i] - a[i-1]), 32'd2);
    chk("rise_n", 32'(rise_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rise_q.size(); i++)
      chk("rise_data", 32'(rise_q[i]), 32'({i[0], w[i]}));

    // slow timing, cfg_wr_low changed mid-LOW
    cfg_wr_low  = 4'd3;
    cfg_wr_high = 4'd2;
    send(8'hA5, RS_DATA, e);
    lows = 0; highs = 0; nrdy = 0;
    for (int i = 0; i < 12; i++) begin
      if (!lcd_wr_n) lows++;
      else if (phy_busy) highs++;
      if (!phy_ready) nrdy++;
      if (i == 1) cfg_wr_low = 4'd0;
      @(negedge clk);
    end
    chk("slow_low",  32'(lows),   32'd4);
    chk("slow_high", 32'(highs),  32'd3);
    chk("slow_nrdy", 32'(nrdy),   32'd6);
    chk("slow_d",    32'(lcd_d),  32'hA5);
    chk("slow_rs",   32'(lcd_rs), 32'd1);

    // two wide frame marks
    phy_ena = 1'b0;
    s0 = stb_n;
    for (int p = 0; p < 2; p++) begin
      e = cyc;
      pulse(10, 10);
      chk("fm_lat", 32'(stb_cyc - e), 32'(LAT));
    end
    chk("fm_stb_n", 32'(stb_n - s0),     32'd2);
    chk("fm_cnt",   32'(phy_frame_cnt), 32'd2);

    // frame counter wraps back to 0 after 256 marks
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s0 = stb_n;
    for (int p = 0; p < 256; p++) pulse(6, 6);
    chk("wrap_stb_n", 32'(stb_n - s0),     32'd256);
    chk("wrap_cnt",   32'(phy_frame_cnt), 32'd0);

    // reset during LOW drops the word
    cfg_wr_low  = 4'd3;
    cfg_wr_high = 4'd2;
    send(8'h5A, RS_DATA, e);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("mid_rst_busy", 32'(phy_busy), 32'd0);
    chk("mid_rst_d",    32'(lcd_d),    32'd0);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      if (!lcd_wr_n) lows++;
      @(negedge clk);
    end
    chk("mid_rst_lows", 32'(lows), 32'd0);

    // short glitch, then a pulse twice the filter length
    s0 = stb_n;
    pulse(FILT_LEN - 2, 15);
    chk("glitch_stb", 32'(stb_n - s0), 32'(GLITCH_STB));
    s0 = stb_n;
    e  = cyc;
    pulse(2 * FILT_LEN, 15);
    chk("pulse8_stb", 32'(stb_n - s0),  32'd1);
    chk("pulse8_lat", 32'(stb_cyc - e), 32'(LAT));
    chk("pulse8_cnt", 32'(phy_frame_cnt), 32'(GLITCH_STB + 1));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_phy_timed.md
Name: lcd_phy_timed

Overview:
- Parametrised successor PHY for the LCD 8080-style parallel write interface.
- Generic bus width; write-strobe low/high durations programmable at run time, so one core serves fast and slow panels and both clock domains.
- Sits between the LCD command/pixel streamer and the pad IOBs: registered pad-side outputs plus OE; the top-level IOB wrapper instantiates the I/O cells.
- Also provides a synchronised frame-mark (tearing) strobe and a frame counter.

Parameters:
DW, 8, data bus width (8 or 16)
TW, 4, width of the timing configuration fields
FCW, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_wr_low  in  TW  wr_n low phase length minus 1, in cycles
cfg_wr_high  in  TW  wr_n high phase length minus 1, in cycles
phy_ena  in  1  pad output enable request
phy_data  in  DW  word to write
phy_rs  in  1  0 = command, 1 = data
phy_valid  in  1  write request
phy_ready  out  1  request accepted when valid & ready
phy_busy  out  1  bus cycle in progress
phy_fmark_stb  out  1  one-cycle pulse on fmark rising edge
phy_frame_cnt  out  FCW  count of fmark rising edges, wraps
lcd_d  out  DW  pad data (registered)
lcd_rs  out  1  pad RS (registered)
lcd_wr_n  out  1  pad write strobe (registered)
lcd_oe  out  1  pad output enable (registered copy of phy_ena)
lcd_fmark  in  1  asynchronous frame mark from panel

Behaviour:
- One clock (clk); reset synchronous, active-high (rst).
- Reset values: lcd_d = 0, lcd_rs = 0, lcd_wr_n = 1, lcd_oe = 0, phy_busy = 0, phy_fmark_stb = 0, phy_frame_cnt = 0, FSM = IDLE, counter = 0.
- FSM states:
  - IDLE: phy_ready = 1. On accept, go to LOW. In the same edge: lcd_d <= phy_data, lcd_rs <= phy_rs, lcd_wr_n <= 0, cnt <= cfg_wr_low.
  - LOW: cnt decrements. At cnt == 0: lcd_wr_n <= 1, cnt <= cfg_wr_high, go to HIGH.
  - HIGH: cnt decrements. phy_ready = 1 only when cnt == 0.
    - Accept in that cycle: reload as from IDLE and go to LOW (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Config sampling: cfg_wr_low is sampled at accept; cfg_wr_high is sampled on LOW-to-HIGH. Changing cfg mid-cycle never corrupts the cycle in progress.
- Timing per word: wr_n low for cfg_wr_low+1 cycles, high for cfg_wr_high+1 cycles. Minimum period is 2 cycles (cfg 0/0), which matches the legacy half-speed PHY.
- lcd_d and lcd_rs are stable for the whole LOW+HIGH window, so the panel latches on the rising edge of wr_n. In IDLE they hold the last value.
- phy_ready is combinational from FSM state and counter, never from phy_valid.
- phy_busy = (state != IDLE).
- lcd_oe <= phy_ena every cycle, independent of the FSM. When phy_ena is low, write cycles still run internally (pads simply tri-stated).
- Frame mark:
  - lcd_fmark passes through a 2-flop synchroniser, then a third flop for edge detect.
  - phy_fmark_stb is registered: 1 for exactly one cycle per rising edge, latency 3 to 4 cycles from the pad edge.
  - phy_frame_cnt increments on the same cycle the strobe is asserted and wraps from all-ones to 0.
- rst mid-cycle: wr_n returns to 1 on the next edge and the in-flight word is dropped. The synchroniser flops are also reset, so no spurious strobe is generated after reset.

Optional Feature:
- Macro: LCD_PHY_FMARK_FILTER_EN.
- With it: the synchronised fmark must be stable for 4 consecutive cycles before the filtered level changes. Edge detect, strobe and counter act on the filtered level. Latency increases by 4 cycles; pulses of 3 cycles or fewer are ignored.
- Without it: unfiltered behaviour as above, with no filter logic synthesised.

Decomposition:
- Shared package lcd_pkg:
  - FSM state encoding (IDLE/LOW/HIGH) as a typedef.
  - RS constants (RS_CMD = 0, RS_DATA = 1).
  - Default timing constants.
- Natural sub-module: lcd_fmark_sync. Contains the synchroniser, optional filter, edge detect and frame counter.

Test Plan:
- Reset, then idle 10 cycles -> lcd_wr_n = 1, lcd_d = 0, phy_ready = 1, phy_busy = 0, phy_frame_cnt = 0.
- cfg 0/0, valid held with 4 words 0x11..0x44 -> accepted every 2 cycles; wr_n pattern 0101...; each rising wr_n edge sees the matching data/rs.
- cfg_wr_low = 3, cfg_wr_high = 2, one word 0xA5 rs = 1 -> wr_n low 4 cycles then high 3 cycles; ready low for 6 cycles after accept; cfg changed mid-LOW has no effect on that word.
- Two fmark pulses 10 cycles wide -> two single-cycle strobes, 3 to 4 cycles after each edge; phy_frame_cnt = 2. With FSM wrap: 256 pulses -> counter returns to 0.
- rst asserted during LOW of word 0x5A -> next cycle wr_n = 1, busy = 0, no further strobe for that word.
- With LCD_PHY_FMARK_FILTER_EN: 2-cycle glitch -> no strobe; 8-cycle pulse -> one strobe, 4 cycles later than the unfiltered build.
